// File: rtl/frame_sender.sv
// frame_sender: packs PackedNum pixels per byte and emits framed bytes
// (HeaderByte0, HeaderByte1, then BytesOut payload bytes) toward a UART TX.
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   unpacked_i            pixel data
//   valid_i / ready_o     pixel stream handshake
//   data_o                byte to the UART TX
//   valid_o / ready_i     byte stream handshake
//   cts_i                 peer RTS; 1 = peer may receive
//   busy_o                high from frame start until the last byte leaves
//   frame_done_o          pulse on the last payload byte handshake
module frame_sender #(
    parameter int         UnpackedWidth  = 1,
    parameter int         PackedNum      = 8,
    parameter int         PacketLenElems = 76800,
    parameter logic [7:0] HeaderByte0    = 8'hA5,
    parameter logic [7:0] HeaderByte1    = 8'h5A
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [UnpackedWidth-1:0] unpacked_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     cts_i,
    output logic                     busy_o,
    output logic                     frame_done_o
);

    localparam int BytesOut = PacketLenElems / PackedNum;
    localparam int PixW  = (PackedNum > 1) ? $clog2(PackedNum) : 1;
    localparam int ByteW = (BytesOut > 1) ? $clog2(BytesOut) : 1;
    localparam int LoadW = $clog2(BytesOut + 1);

    localparam logic [PixW-1:0]  PixLast  = PixW'(PackedNum - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(BytesOut - 1);
    localparam logic [LoadW-1:0] LoadAll  = LoadW'(BytesOut);

    typedef enum logic [1:0] {
        IDLE,
        HDR0,
        HDR1,
        PAYLOAD
    } state_t;

    state_t            state_q;
    logic [PixW-1:0]   pix_cnt_q;
    logic [ByteW-1:0]  byte_cnt_q;
    logic [LoadW-1:0]  load_cnt_q;
    logic [7:0]        pack_q;
    logic [7:0]        pack_d;
    logic [7:0]        data_q;
    logic              out_full_q;
    logic              launched_q;

    logic out_hs;
    logic pix_hs;
    logic byte_done;
    logic last_hs;

    // Once launched, a byte stays valid even if the peer drops RTS.
    assign valid_o = out_full_q & (cts_i | launched_q);
    assign out_hs  = valid_o & ready_i;

    // load_cnt_q stops pixels of the next frame from being packed
    // behind the last payload byte of the current one.
    assign ready_o = (state_q == PAYLOAD)
                   & (load_cnt_q != LoadAll)
                   & ((pix_cnt_q != PixLast) | ~out_full_q | out_hs);

    assign pix_hs    = valid_i & ready_o;
    assign byte_done = pix_hs & (pix_cnt_q == PixLast);
    assign last_hs   = (state_q == PAYLOAD) & out_hs
                     & (byte_cnt_q == ByteLast);

    assign frame_done_o = last_hs;
    assign busy_o       = (state_q != IDLE) | out_full_q;
    assign data_o       = data_q;

    // First pixel of a byte lands at the LSB.
    always_comb begin
        pack_d = pack_q;
        pack_d[int'(pix_cnt_q) * UnpackedWidth +: UnpackedWidth] = unpacked_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
            load_cnt_q <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            out_full_q <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            if (out_hs) begin
                out_full_q <= 1'b0;
                launched_q <= 1'b0;
            end else if (valid_o) begin
                launched_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (valid_i) state_q <= HDR0;
                end
                HDR0: begin
                    if (!out_full_q) begin
                        data_q     <= HeaderByte0;
                        out_full_q <= 1'b1;
                    end else if (out_hs) begin
                        data_q     <= HeaderByte1;
                        out_full_q <= 1'b1;
                        state_q    <= HDR1;
                    end
                end
                HDR1: begin
                    if (out_hs) state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (out_hs) begin
                        if (last_hs) begin
                            byte_cnt_q <= '0;
                            load_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    if (pix_hs) begin
                        pack_q <= pack_d;
                        if (byte_done) begin
                            // Overrides the clear from a same-cycle handshake.
                            pix_cnt_q  <= '0;
                            data_q     <= pack_d;
                            out_full_q <= 1'b1;
                            load_cnt_q <= load_cnt_q + 1'b1;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: directed and randomized checks of frame_sender
// against a frame/packing reference model.
module tb_frame_sender;

    localparam int UW  = 1;
    localparam int PN  = 8;
    localparam int PLE = 64;
    localparam int BO  = PLE / PN;
    localparam int FB  = BO + 2;

    logic          clk;
    logic          rst_n;
    logic [UW-1:0] unpacked;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cts;
    logic          busy;
    logic          frame_done;

    int checks;
    int failures;

    logic [UW-1:0] pix [256];
    int            pidx;
    logic [7:0]    out_q [$];
    int            done_at [$];
    int            gaps [$];
    int            low_run;
    bit            had_high;
    logic          prev_v;
    logic          prev_hs;
    logic [7:0]    prev_d;

    frame_sender #(
        .UnpackedWidth (UW),
        .PackedNum     (PN),
        .PacketLenElems(PLE)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .unpacked_i  (unpacked),
        .valid_i     (in_valid),
        .ready_o     (in_ready),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .ready_i     (out_ready),
        .cts_i       (cts),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int base);
        int v;
        v = 0;
        for (int j = 0; j < PN; j++)
            v += int'(pix[base + j]) << (j * UW);
        return 8'(v);
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            pix[i] = UW'($urandom_range((1 << UW) - 1));
    endtask

    task automatic clear_obs();
        out_q.delete();
        done_at.delete();
        pidx = 0;
    endtask

    task automatic compare(input string tag, input int nframes);
        logic [7:0] e [$];
        for (int f = 0; f < nframes; f++) begin
            e.push_back(8'hA5);
            e.push_back(8'h5A);
            for (int b = 0; b < BO; b++)
                e.push_back(exp_byte(f * PLE + b * PN));
        end
        chk({tag, "_len"}, out_q.size(), e.size());
        for (int i = 0; i < e.size() && i < out_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(out_q[i]), 32'(e[i]));
    endtask

    // Drives pixels from pix[pidx..npix-1] until nbytes bytes were seen.
    // Starts and ends just after a rising edge.
    task automatic stream(input int npix, input int nbytes, input int rv,
                          input int rr, input int budget,
                          output int stalls);
        int n;
        bit acc;
        bit seen;
        n = 0;
        acc = 0;
        seen = 0;
        stalls = 0;
        while (out_q.size() < nbytes && n < budget) begin
            if (!in_valid || acc)
                in_valid = (pidx < npix) && ($urandom_range(99) >= rv);
            if (pidx < npix) unpacked = pix[pidx];
            out_ready = ($urandom_range(99) >= rr);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_ready) seen = 1;
            if (acc) pidx++;
            else if (in_valid && seen) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_timeout", 32'(n < budget), 1);
    endtask

    // Output monitor: byte log, frame_done positions, busy gaps,
    // and hold-until-handshake check on the byte channel.
    initial begin
        prev_v = 0;
        prev_hs = 0;
        prev_d = 0;
        low_run = 0;
        had_high = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                prev_hs = 0;
            end else begin
                if (prev_v && !prev_hs) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data", 32'(out_data), 32'(prev_d));
                end
                if (out_valid && out_ready) out_q.push_back(out_data);
                if (frame_done) done_at.push_back(out_q.size());
                if (!busy) begin
                    low_run++;
                end else begin
                    if (had_high && low_run > 0) gaps.push_back(low_run);
                    low_run = 0;
                    had_high = 1;
                end
                prev_v = out_valid;
                prev_hs = out_valid && out_ready;
                prev_d = out_data;
            end
        end
    end

    initial begin
        int stalls;
        int w;
        bit vseen;
        logic [7:0] b0;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        unpacked = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cts = 1'b1;
        pidx = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame: header latency, known first bytes, throughput
        clear_obs();
        fill(PLE);
        for (int i = 0; i < 16; i++) pix[i] = '0;
        pix[0] = '1;
        pix[15] = '1;
        in_valid = 1'b1;
        unpacked = pix[0];
        @(negedge clk);
        chk("t0_ready", 32'(in_ready), 0);
        chk("t0_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 0);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_data", 32'(out_data), 32'h5A);
        chk("t3_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("t4_ready", 32'(in_ready), 1);
        pidx = 1;
        @(posedge clk);
        #1;
        stream(PLE, FB, 0, 0, 500, stalls);
        chk("f1_stalls", stalls, 0);
        chk("f1_byte2", 32'(out_q.size() > 2 ? out_q[2] : 8'h00), 32'h01);
        chk("f1_byte3", 32'(out_q.size() > 3 ? out_q[3] : 8'h00), 32'h80);
        compare("f1", 1);
        chk("f1_done_cnt", done_at.size(), 1);
        if (done_at.size() > 0) chk("f1_done_at", done_at[0], FB);

        // CTS hold-off on the first payload byte
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        fill(PLE);
        in_valid = 1'b1;
        unpacked = pix[0];
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("cts_ready_up", 32'(in_ready), 1);
        pidx = 1;
        @(posedge clk);
        #1;
        cts = 1'b0;
        vseen = 0;
        repeat (20) begin
            unpacked = pix[pidx];
            @(negedge clk);
            if (out_valid) vseen = 1;
            if (in_ready) pidx++;
            @(posedge clk);
            #1;
        end
        chk("cts_pix_taken", pidx, 2 * PN - 1);
        chk("cts_no_valid", 32'(vseen), 0);
        @(negedge clk);
        chk("cts_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        cts = 1'b1;
        unpacked = pix[pidx];
        b0 = exp_byte(0);
        @(negedge clk);
        chk("cts_valid_up", 32'(out_valid), 1);
        chk("cts_data", 32'(out_data), 32'(b0));
        if (in_valid && in_ready) pidx++;
        @(posedge clk);
        #1;
        stream(PLE, FB, 0, 0, 500, stalls);
        compare("cts", 1);

        // Launched byte held while CTS drops
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        fill(PLE);
        in_valid = 1'b1;
        unpacked = pix[0];
        out_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("lch_valid", 32'(out_valid), 1);
        chk("lch_data", 32'(out_data), 32'hA5);
        @(posedge clk);
        #1;
        cts = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("lch_hold_v", 32'(out_valid), 1);
            chk("lch_hold_d", 32'(out_data), 32'hA5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("lch_hs_v", 32'(out_valid), 1);
        @(negedge clk);
        chk("lch_next_gated", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        cts = 1'b1;
        stream(PLE, FB, 0, 0, 500, stalls);
        compare("lch", 1);

        // Random backpressure, three frames
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        fill(3 * PLE);
        stream(3 * PLE, 3 * FB, 30, 40, 4000, stalls);
        compare("rnd", 3);
        chk("rnd_done_cnt", done_at.size(), 3);

        // Mid-frame reset after five payload bytes
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        fill(PLE);
        stream(PLE, 7, 0, 0, 200, stalls);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(in_ready), 0);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_data", 32'(out_data), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        fill(PLE);
        stream(PLE, FB, 0, 0, 500, stalls);
        compare("mrst", 1);
        chk("mrst_done_cnt", done_at.size(), 1);

        // Back-to-back frames with in_valid held high
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        gaps.delete();
        had_high = 0;
        low_run = 0;
        fill(3 * PLE);
        stream(3 * PLE, 3 * FB, 0, 0, 1000, stalls);
        compare("b2b", 3);
        chk("b2b_gap_cnt", gaps.size(), 2);
        foreach (gaps[i]) chk($sformatf("b2b_gap[%0d]", i), gaps[i], 1);
        chk("b2b_done_cnt", done_at.size(), 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
